// File: rtl/ring_bus_router.sv
// Ring interconnect: per-node TX FIFOs feed a unidirectional slot ring, one hop per clock.

// fifo: generic show-ahead FIFO, head visible while level != 0.
// Latency: a pushed entry is at the head one cycle after the push edge.
// Backpressure: caller must not push when level == DEPTH nor pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// ring_bus_router: N-node ring, packets delivered at dest with source ID attached.
// Latency: h+1 cycles from tx handshake to rx_valid (h = hops, self-address = full lap).
// Backpressure: tx_ready low when the node FIFO is full; rx has none; ring traffic beats injection.
module ring_bus_router #(
    parameter int N_NODES    = 5,
    parameter int DATA_W     = 8,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_NODES-1:0]                        tx_valid,
    output logic [N_NODES-1:0]                        tx_ready,
    input  logic [N_NODES*ID_W-1:0]                   tx_dest,
    input  logic [N_NODES*DATA_W-1:0]                 tx_data,
    output logic [N_NODES-1:0]                        rx_valid,
    output logic [N_NODES*ID_W-1:0]                   rx_src,
    output logic [N_NODES*DATA_W-1:0]                 rx_data,
    output logic [N_NODES-1:0]                        err_drop,
    output logic [N_NODES*($clog2(FIFO_DEPTH)+1)-1:0] fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = ID_W + DATA_W;
    localparam logic [ID_W:0] N_ID = (ID_W+1)'(N_NODES);

    typedef struct packed {
        logic              vld;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   dest;
        logic [DATA_W-1:0] dat;
    } slot_t;

    slot_t [N_NODES-1:0]         stage_q;
    slot_t [N_NODES-1:0]         stage_d;
    slot_t [N_NODES-1:0]         in_s;
    logic  [N_NODES-1:0]         deliver;
    logic  [N_NODES-1:0]         pop;
    logic  [N_NODES-1:0]         drop_d;
    logic  [N_NODES-1:0][PW-1:0] head;
    logic  [N_NODES-1:0][LW-1:0] lvl;

    assign fifo_level = lvl;

    for (genvar g = 0; g < N_NODES; g++) begin : g_node
        assign tx_ready[g] = (lvl[g] != LW'(FIFO_DEPTH)) && !rst;

        fifo #(.W(PW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (tx_valid[g] && tx_ready[g]),
            .push_dat ({tx_dest[g*ID_W +: ID_W], tx_data[g*DATA_W +: DATA_W]}),
            .pop      (pop[g]),
            .head_dat (head[g]),
            .level    (lvl[g])
        );
    end

    always_comb begin
        in_s    = '0;
        stage_d = '0;
        deliver = '0;
        pop     = '0;
        drop_d  = '0;
        for (int i = 0; i < N_NODES; i++) begin
            in_s[i]    = stage_q[(i + N_NODES - 1) % N_NODES];
            deliver[i] = in_s[i].vld && (in_s[i].dest == ID_W'(i));
            // A slot consumed by delivery is reusable for injection on the same edge.
            pop[i]     = (!in_s[i].vld || deliver[i]) && (lvl[i] != '0) && !rst;
            if (in_s[i].vld && !deliver[i]) begin
                stage_d[i] = in_s[i];
            end else if (pop[i]) begin
                if ({1'b0, head[i][PW-1 -: ID_W]} < N_ID) begin
                    stage_d[i].vld  = 1'b1;
                    stage_d[i].src  = ID_W'(i);
                    stage_d[i].dest = head[i][PW-1 -: ID_W];
                    stage_d[i].dat  = head[i][DATA_W-1:0];
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q  <= '0;
            rx_valid <= '0;
            rx_src   <= '0;
            rx_data  <= '0;
            err_drop <= '0;
        end else begin
            stage_q  <= stage_d;
            rx_valid <= deliver;
            err_drop <= drop_d;
            for (int i = 0; i < N_NODES; i++) begin
                if (deliver[i]) begin
                    rx_src[i*ID_W +: ID_W]     <= in_s[i].src;
                    rx_data[i*DATA_W +: DATA_W] <= in_s[i].dat;
                end
            end
        end
    end
endmodule

// File: doc/ring_bus_router.md
Name: ring_bus_router

Overview:
- Parametrised N-node unidirectional ring interconnect. It replaces fixed point-to-point modport wiring between sub-blocks with a packetised, buffered ring.
- Each node injects {dest, data} packets through a small TX FIFO. Packets circulate one hop per clock in per-node slot registers and are delivered at the destination node with the source ID attached.
- Sits between the functional sub-blocks of a top level. Each sub-block connects to one node index.

Parameters:
- N_NODES, 5, number of ring nodes (2..16)
- DATA_W, 8, payload width
- ID_W, 4, node-ID width (must satisfy 2**ID_W >= N_NODES)
- FIFO_DEPTH, 4, per-node TX FIFO entries (power of 2, >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- tx_valid  input  N_NODES  per-node packet offer
- tx_ready  output  N_NODES  per-node FIFO not full; forced 0 while rst=1
- tx_dest  input  N_NODES*ID_W  per-node destination ID (node i at bits [i*ID_W +: ID_W])
- tx_data  input  N_NODES*DATA_W  per-node payload
- rx_valid  output  N_NODES  one-cycle delivery pulse; no backpressure
- rx_src  output  N_NODES*ID_W  source ID of delivered packet
- rx_data  output  N_NODES*DATA_W  delivered payload
- err_drop  output  N_NODES  one-cycle pulse: packet dropped for illegal dest
- fifo_level  output  N_NODES*($clog2(FIFO_DEPTH)+1)  per-node TX FIFO occupancy

Behaviour:
- Reset (sync, rst=1 at a rising edge) produces:
  - all FIFOs empty and fifo_level=0
  - all slot registers invalid
  - rx_valid=0, rx_src=0, rx_data=0, err_drop=0
  - tx_ready=0 while rst is high
  - Packets in flight are discarded. A tx handshake in the same cycle as rst is ignored.
- TX handshake: a write happens at an edge where tx_valid[i] && tx_ready[i]. tx_ready[i] = (fifo_level[i] != FIFO_DEPTH) && !rst. A simultaneous push and pop on a full FIFO is not allowed; tx_ready stays 0 when full.
- Slot register stage[i] = {valid, src, dest, data}. Node i sees the incoming slot in = stage[(i-1) mod N_NODES] (node 0 sees stage[N_NODES-1]).
- Per-node action each edge, in priority order:
  1. Delivery: if in.valid && in.dest==i, then rx_valid[i]<=1, rx_src/rx_data<=in fields, and the slot is freed locally.
  2. Forward: otherwise, if in.valid, stage[i]<=in unchanged. This traffic has priority over injection.
  3. Injection: if the slot is free (empty, or freed by delivery in this same edge) and the FIFO is not empty, pop the head.
     - If head.dest < N_NODES: stage[i]<={1,i,dest,data}.
     - Else: discard it, pulse err_drop[i], and leave stage[i] invalid.
  4. Otherwise stage[i].valid<=0.
- rx_valid and err_drop are registered single-cycle pulses. rx_src/rx_data hold their last value when rx_valid=0.
- Self-addressed packet (dest==i) makes a full lap and is delivered at node i after N_NODES hops.
- Latency, with an empty FIFO and free slots:
  - h = (dest - src) mod N_NODES, with h=0 meaning h=N_NODES.
  - rx_valid rises h+1 cycles after the tx handshake edge.
  - FIFO write to pop is 1 cycle minimum.
- Ordering: packets from the same src to the same dest are delivered in FIFO order.
- No fairness: a node whose incoming slot is continuously valid and not addressed to it may starve. This is permitted; verify that no packet is lost or duplicated.
- fifo_level updates at the edge of a push/pop; push+pop in the same edge leaves it unchanged.
- Illegal-dest check is done at injection, not at TX accept.

Test Plan:
- Single packet, N=5: node 0 sends dest=3, data=0xA5 at edge E0 → rx_valid[3]=1 after E4 with rx_src=0, rx_data=0xA5; no other rx_valid.
- Wrap and self-address: node 4 sends dest=0 → delivered 2 cycles after handshake. Node 2 sends dest=2 → delivered at node 2 after 6 cycles with rx_src=2.
- Simultaneous injection: all 5 nodes send dest=(i+2) mod 5 at the same edge → 5 deliveries, each 3 cycles later, with correct src/data and no loss.
- FIFO full and starvation: hold node 1's incoming slot busy with traffic from node 0 to node 3. Push 4 packets at node 1 → tx_ready[1]=0, fifo_level[1]=4. Stop the node 0 traffic → node 1 drains in order and tx_ready[1] returns to 1.
- Illegal dest: node 0 sends dest=7 (N=5) → err_drop[0] pulses 1 cycle after the handshake; no rx_valid anywhere.
- Reset mid-flight: inject 3 packets, assert rst for 1 cycle before delivery → no rx_valid afterward, all fifo_level=0, tx_ready=0 during rst and 1 after.
